// File: rtl/qmc_pkg.sv
// Shared helpers for the qmc launch/collect controller and its FIFOs.
package qmc_pkg;

  // Width of a counter that must hold every value in [0, depth].
  function automatic int cnt_w(input int depth);
    if (depth < 1) return 1;
    return $clog2(depth + 1);
  endfunction

  // Width of a pointer that addresses depth entries (at least one bit).
  function automatic int ptr_w(input int depth);
    if (depth <= 1) return 1;
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/event_align_fifo_arr.sv
// In-order FIFO of N-element sidecar words. The popped word appears on
// pop_data in the cycle after the pop, lined up with a registered result.
module event_align_fifo_arr
  import qmc_pkg::*;
#(
  parameter int N     = 1,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data [0:N-1],
  input  logic          pop,
  output logic [DW-1:0] pop_data  [0:N-1],
  output logic          empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [DW-1:0] mem [0:DEPTH-1][0:N-1];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          push_en;
  logic          pop_en;

  // Wrap at DEPTH-1 explicitly so non-power-of-two depths stay in range.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_en)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write and registered read of the popped entry.
  always_ff @(posedge clk) begin
    if (push_en) begin
      for (int i = 0; i < N; i++) mem[wr_ptr][i] <= push_data[i];
    end
    if (pop_en) begin
      for (int i = 0; i < N; i++) pop_data[i] <= mem[rd_ptr][i];
    end
  end

endmodule

// File: rtl/join_out_fifo.sv
// In-order output queue for joined {result, sidecar} words. The head is read
// straight from the storage flops and forced to zero while the queue is empty,
// so the outputs are clean after reset and hold steady while stalled.
module join_out_fifo
  import qmc_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [W-1:0] rd_data
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [W-1:0]  mem [0:DEPTH-1];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          wr_go;
  logic          rd_go;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign full     = (count == CW'(DEPTH));
  assign rd_valid = (count != '0);
  assign wr_go    = wr_en && !full;
  assign rd_go    = rd_valid && rd_ready;
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_go) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_go) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_go, rd_go})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; the read side is the masked head mux above.
  always_ff @(posedge clk) begin
    if (wr_go) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/qmc_launch_ctrl.sv
// Credit-gated launch/collect controller around an in-order, variable-latency
// arithmetic core. Sidecars wait in an align FIFO while the operand is in the
// core; each result is re-joined with its sidecar and queued for output.
module qmc_launch_ctrl
  import qmc_pkg::*;
#(
  parameter int N     = 1,
  parameter int DW    = 32,
  parameter int OW    = 32,
  parameter int RW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [OW-1:0] in_operand,
  input  logic [DW-1:0] in_side    [0:N-1],
  output logic          core_start,
  output logic [OW-1:0] core_operand,
  input  logic          core_valid,
  input  logic [RW-1:0] core_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_result,
  output logic [DW-1:0] out_side   [0:N-1],
  output logic          busy,
  output logic          err_underflow
);

  localparam int CW = cnt_w(DEPTH);
  localparam int W  = RW + N * DW;

  // Credits cover everything between launch and output handshake: items in
  // the core, in the join register and in the output queue. That bound keeps
  // both FIFOs from overflowing without any extra full checks here.
  logic [CW-1:0] cnt;

  logic          launch_p0;
  logic          collect_p0;
  logic          orphan_p0;
  logic          align_empty;
  logic          credit_ret;

  logic          vld_p1;
  logic [RW-1:0] join_result_p1;
  logic [DW-1:0] side_p1 [0:N-1];
  logic [W-1:0]  join_data_p1;
  logic [W-1:0]  out_data;

  // ---- stage p0: launch and collect decisions ----
  assign in_ready     = (cnt < CW'(DEPTH));
  assign launch_p0    = in_valid && in_ready;
  assign core_start   = launch_p0;
  assign core_operand = in_operand;

  assign collect_p0   = core_valid && !align_empty;
  assign orphan_p0    = core_valid && align_empty;
  assign credit_ret   = out_valid && out_ready;
  assign busy         = (cnt != '0);

  event_align_fifo_arr #(
    .N     (N),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_align (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (launch_p0),
    .push_data (in_side),
    .pop       (collect_p0),
    .pop_data  (side_p1),
    .empty     (align_empty)
  );

  // Credit counter: +1 on launch, -1 on output handshake, both cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      case ({launch_p0, credit_ret})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // A result with no sidecar waiting is dropped and flagged until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_underflow <= 1'b0;
    end else if (orphan_p0) begin
      err_underflow <= 1'b1;
    end
  end

  // ---- stage p1: join register, paired with the registered sidecar ----
  // Join-valid tracks each collect; it may be reloaded every cycle because its
  // previous contents are written to the output queue in that same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= collect_p0;
    end
  end

  // Join result data; only meaningful while vld_p1 is set.
  always_ff @(posedge clk) begin
    if (collect_p0) join_result_p1 <= core_result;
  end

  // Pack {result, side[0], ..., side[N-1]} with side[0] just below the result.
  always_comb begin
    join_data_p1 = '0;
    join_data_p1[W-1 -: RW] = join_result_p1;
    for (int i = 0; i < N; i++) begin
      join_data_p1[(N-1-i)*DW +: DW] = side_p1[i];
    end
  end

  // ---- stage p2: output queue head ----
  join_out_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_out (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (vld_p1),
    .wr_data  (join_data_p1),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .rd_data  (out_data)
  );

  // Unpack the head word back into result and sidecar elements.
  always_comb begin
    out_result = out_data[W-1 -: RW];
    for (int i = 0; i < N; i++) begin
      out_side[i] = out_data[(N-1-i)*DW +: DW];
    end
  end

endmodule

// File: tb/tb_qmc_launch_ctrl.sv
// Directed bench for qmc_launch_ctrl: a DEPTH=4 instance for timing, fill,
// underflow and reset steps, and a DEPTH=3 instance for an in-order stream.
module tb_qmc_launch_ctrl;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int OW = 32;
  localparam int RW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  // Core arithmetic used by the bench's stand-in core.
  function automatic logic [31:0] core_fn(input logic [31:0] op);
    return op * 32'd3 + 32'h100;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- instance A: DEPTH = 4 ----------------
  logic          a_in_valid = 1'b0;
  logic          a_in_ready;
  logic [OW-1:0] a_in_operand = '0;
  logic [DW-1:0] a_in_side [0:N-1];
  logic          a_core_start;
  logic [OW-1:0] a_core_operand;
  logic          a_core_valid;
  logic [RW-1:0] a_core_result;
  logic          a_out_valid;
  logic          a_out_ready = 1'b0;
  logic [RW-1:0] a_out_result;
  logic [DW-1:0] a_out_side [0:N-1];
  logic          a_busy;
  logic          a_err;

  qmc_launch_ctrl #(.N(N), .DW(DW), .OW(OW), .RW(RW), .DEPTH(4)) a_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_operand(a_in_operand), .in_side(a_in_side),
    .core_start(a_core_start), .core_operand(a_core_operand),
    .core_valid(a_core_valid), .core_result(a_core_result),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_result(a_out_result), .out_side(a_out_side),
    .busy(a_busy), .err_underflow(a_err)
  );

  // Stand-in core for A: in-order, latency chosen per launch through a_lat.
  logic [31:0] a_op_q [$];
  int          a_due_q [$];
  int          a_last_due = 0;
  int          a_lat = 1;
  int          a_d;
  logic        a_model_cv = 1'b0;
  logic [31:0] a_model_res = '0;
  logic        a_inject = 1'b0;

  assign a_core_valid  = a_model_cv | a_inject;
  assign a_core_result = a_inject ? 32'hDEAD_BEEF : a_model_res;

  always @(negedge clk) begin
    if (!rst_n) begin
      a_op_q.delete(); a_due_q.delete(); a_model_cv = 1'b0; a_last_due = 0;
    end else begin
      a_model_cv = 1'b0;
      if (a_due_q.size() > 0 && a_due_q[0] == cyc) begin
        a_model_cv  = 1'b1;
        a_model_res = core_fn(a_op_q[0]);
        void'(a_op_q.pop_front());
        void'(a_due_q.pop_front());
      end
      if (a_core_start) begin
        a_d = cyc + a_lat;
        if (a_d <= a_last_due) a_d = a_last_due + 1;
        a_op_q.push_back(a_core_operand);
        a_due_q.push_back(a_d);
        a_last_due = a_d;
      end
    end
  end

  // ---------------- instance B: DEPTH = 3 ----------------
  logic          b_in_valid = 1'b0;
  logic          b_in_ready;
  logic [OW-1:0] b_in_operand = '0;
  logic [DW-1:0] b_in_side [0:N-1];
  logic          b_core_start;
  logic [OW-1:0] b_core_operand;
  logic          b_core_valid;
  logic [RW-1:0] b_core_result;
  logic          b_out_valid;
  logic          b_out_ready = 1'b0;
  logic [RW-1:0] b_out_result;
  logic [DW-1:0] b_out_side [0:N-1];
  logic          b_busy;
  logic          b_err;

  qmc_launch_ctrl #(.N(N), .DW(DW), .OW(OW), .RW(RW), .DEPTH(3)) b_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_operand(b_in_operand), .in_side(b_in_side),
    .core_start(b_core_start), .core_operand(b_core_operand),
    .core_valid(b_core_valid), .core_result(b_core_result),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_result(b_out_result), .out_side(b_out_side),
    .busy(b_busy), .err_underflow(b_err)
  );

  logic [31:0] b_op_q [$];
  int          b_due_q [$];
  int          b_last_due = 0;
  int          b_d;
  int          b_launched = 0;
  int          b_lat_tab [10] = '{1, 4, 2, 1, 3, 1, 2, 1, 4, 1};
  logic        b_model_cv = 1'b0;
  logic [31:0] b_model_res = '0;

  assign b_core_valid  = b_model_cv;
  assign b_core_result = b_model_res;

  always @(negedge clk) begin
    if (!rst_n) begin
      b_op_q.delete(); b_due_q.delete(); b_model_cv = 1'b0; b_last_due = 0;
    end else begin
      b_model_cv = 1'b0;
      if (b_due_q.size() > 0 && b_due_q[0] == cyc) begin
        b_model_cv  = 1'b1;
        b_model_res = core_fn(b_op_q[0]);
        void'(b_op_q.pop_front());
        void'(b_due_q.pop_front());
      end
      if (b_core_start) begin
        b_d = cyc + b_lat_tab[b_launched % 10];
        if (b_d <= b_last_due) b_d = b_last_due + 1;
        b_op_q.push_back(b_core_operand);
        b_due_q.push_back(b_d);
        b_last_due = b_d;
        b_launched++;
      end
    end
  end

  // Output checker for B: items must leave in launch order with their sidecars.
  int          b_rcv = 0;
  int          b_sent = 0;
  logic [31:0] b_exp_op;
  always @(negedge clk) begin
    if (rst_n && b_out_valid && b_out_ready) begin
      b_exp_op = 32'h100 + b_rcv;
      chk("b_stream_res", b_out_result, core_fn(b_exp_op));
      chk("b_stream_side0", b_out_side[0], b_exp_op[7:0]);
      chk("b_stream_side1", b_out_side[1], b_exp_op[7:0] ^ 8'hFF);
      b_rcv++;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic a_drive(input logic v, input logic [31:0] op);
    a_in_valid   = v;
    a_in_operand = op;
    a_in_side[0] = op[7:0];
    a_in_side[1] = op[7:0] ^ 8'hFF;
  endtask

  // Wait (bounded) for the next A output handshake and check its contents.
  task automatic expect_out(input string tag, input logic [31:0] op);
    int w;
    w = 0;
    @(negedge clk);
    while (!(a_out_valid && a_out_ready) && w < 40) begin
      @(posedge clk); #1; @(negedge clk);
      w++;
    end
    chk({tag, "_vld"}, a_out_valid, 1'b1);
    chk({tag, "_res"}, a_out_result, core_fn(op));
    chk({tag, "_side0"}, a_out_side[0], op[7:0]);
    chk({tag, "_side1"}, a_out_side[1], op[7:0] ^ 8'hFF);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_in_side[0] = '0; a_in_side[1] = '0;
    b_in_side[0] = '0; b_in_side[1] = '0;

    // Reset values while rst_n is low.
    @(negedge clk);
    chk("rst_in_ready", a_in_ready, 1'b1);
    chk("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_err", a_err, 1'b0);
    chk("rst_out_result", a_out_result, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // Single item: latency 3, output exactly 5 cycles after accept.
    a_lat = 3;
    a_out_ready = 1'b1;
    a_in_valid = 1'b1; a_in_operand = 32'h5; a_in_side[0] = 8'hA; a_in_side[1] = 8'hB;
    @(negedge clk);
    chk("one_core_start", a_core_start, 1'b1);
    chk("one_core_operand", a_core_operand, 32'h5);
    tick();
    a_in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("one_wait_vld", a_out_valid, 1'b0);
      chk("one_wait_busy", a_busy, 1'b1);
      tick();
    end
    @(negedge clk);
    chk("one_out_valid", a_out_valid, 1'b1);
    chk("one_out_result", a_out_result, 32'h10F);
    chk("one_side0", a_out_side[0], 8'hA);
    chk("one_side1", a_out_side[1], 8'hB);
    tick();
    @(negedge clk);
    chk("one_busy_done", a_busy, 1'b0);
    chk("one_vld_done", a_out_valid, 1'b0);
    tick();

    // Orphan core_valid: sticky error, no output, no credit change.
    a_inject = 1'b1;
    tick();
    a_inject = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("uf_err", a_err, 1'b1);
      chk("uf_out_valid", a_out_valid, 1'b0);
      chk("uf_busy", a_busy, 1'b0);
      tick();
    end

    // Fill four credits with the output stalled.
    a_lat = 1;
    a_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_drive(1'b1, 32'h10 + i);
      @(negedge clk);
      chk("fill_in_ready", a_in_ready, 1'b1);
      tick();
    end
    a_drive(1'b1, 32'h14);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("full_in_ready", a_in_ready, 1'b0);
      chk("full_no_start", a_core_start, 1'b0);
      tick();
    end
    @(negedge clk);
    chk("stall_head_vld", a_out_valid, 1'b1);
    chk("stall_head_res", a_out_result, core_fn(32'h10));
    tick();
    @(negedge clk);
    chk("stall_hold_res", a_out_result, core_fn(32'h10));
    chk("stall_hold_side0", a_out_side[0], 8'h10);
    tick();

    // Release the output: first handshake, credit back the next cycle.
    a_out_ready = 1'b1;
    @(negedge clk);
    chk("h0_in_ready", a_in_ready, 1'b0);
    chk("h0_res", a_out_result, core_fn(32'h10));
    chk("h0_side1", a_out_side[1], 8'h10 ^ 8'hFF);
    tick();
    @(negedge clk);
    chk("h1_in_ready", a_in_ready, 1'b1);
    chk("h1_core_start", a_core_start, 1'b1);
    chk("h1_res", a_out_result, core_fn(32'h11));
    tick();
    // Launch and handshake landed together, so one more launch refills.
    a_out_ready = 1'b0;
    a_drive(1'b1, 32'h15);
    @(negedge clk);
    chk("simul_cnt", a_dut.cnt, 3);
    chk("simul_start", a_core_start, 1'b1);
    tick();
    a_drive(1'b0, 32'h0);
    @(negedge clk);
    chk("refull_in_ready", a_in_ready, 1'b0);
    tick();
    a_out_ready = 1'b1;
    expect_out("drain12", 32'h12);
    expect_out("drain13", 32'h13);
    expect_out("drain14", 32'h14);
    expect_out("drain15", 32'h15);
    @(negedge clk);
    chk("drain_busy", a_busy, 1'b0);
    chk("drain_vld", a_out_valid, 1'b0);
    tick();

    // DEPTH=3 stream: 10 items, mixed latencies, out_ready toggling 1010.
    for (int k = 0; k < 400 && b_rcv < 10; k++) begin
      b_in_valid   = (b_sent < 10);
      b_in_operand = 32'h100 + b_sent;
      b_in_side[0] = b_in_operand[7:0];
      b_in_side[1] = b_in_operand[7:0] ^ 8'hFF;
      b_out_ready  = ~b_out_ready;
      @(negedge clk);
      if (b_in_valid && b_in_ready) b_sent++;
      tick();
    end
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    chk("b_all_received", b_rcv, 10);
    for (int k = 0; k < 5; k++) tick();
    @(negedge clk);
    chk("b_no_extra", b_rcv, 10);
    chk("b_idle_vld", b_out_valid, 1'b0);
    chk("b_idle_busy", b_busy, 1'b0);
    chk("b_no_err", b_err, 1'b0);
    tick();

    // Reset with three items outstanding.
    a_out_ready = 1'b0;
    a_lat = 1; a_drive(1'b1, 32'h20); tick();
    a_drive(1'b1, 32'h21); tick();
    a_lat = 8; a_drive(1'b1, 32'h22); tick();
    a_drive(1'b0, 32'h0);
    tick(); tick(); tick();
    @(negedge clk);
    chk("pre_rst_vld", a_out_valid, 1'b1);
    chk("pre_rst_busy", a_busy, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", a_out_valid, 1'b0);
    chk("mid_rst_busy", a_busy, 1'b0);
    chk("mid_rst_in_ready", a_in_ready, 1'b1);
    chk("mid_rst_err", a_err, 1'b0);
    chk("mid_rst_res", a_out_result, 32'h0);
    chk("mid_rst_side0", a_out_side[0], 8'h0);
    @(posedge clk); @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", a_in_ready, 1'b1);
    chk("post_rst_busy", a_busy, 1'b0);
    chk("post_rst_vld", a_out_valid, 1'b0);
    @(posedge clk); #1;
    a_lat = 2;
    a_out_ready = 1'b1;
    a_drive(1'b1, 32'h30);
    @(negedge clk);
    chk("fresh_start", a_core_start, 1'b1);
    tick();
    a_drive(1'b0, 32'h0);
    expect_out("fresh", 32'h30);
    @(negedge clk);
    chk("fresh_busy", a_busy, 1'b0);
    chk("fresh_no_extra", a_out_valid, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
